lvds_iq_deframer: RTL and testbench
===================================

# lvds_iq_deframer

- Receive-side counterpart of the LVDS I/Q framer.
- Takes the 2-bit-per-clock deserialized LVDS stream from the DDR input stage and locks to the 32-bit sample-word framing.
- Classifies each aligned word as data, end-of-message, idle or invalid, and outputs signed 13-bit I/Q samples with a valid strobe.
- Sits between the DDR receiver and the sample FIFO / loopback checker in the `s_rx_ck` domain.

## Interface
Parameters:
- MISS_LIMIT, 3: consecutive invalid aligned words that drop lock (1..15).

Ports:
- clk  in  1  deserializer clock (`s_rx_ck`); all logic on its rising edge.
- reset  in  1  asynchronous, active-high; clears all state and outputs.
- rx_en  in  1  when low: shift register cleared, state forced to HUNT, no strobes.
- rx_d  in  2  bit pair per clock; rx_d[0] is the earlier bit on the wire.
- iq_valid  out  1  one-cycle strobe; i_out and q_out hold a new sample.
- i_out  out  13  I sample, two's complement.
- q_out  out  13  Q sample, two's complement.
- eom  out  1  one-cycle strobe on an end-of-message word.
- locked  out  1  high in LOCKED state.
- err_count  out  8  saturating invalid-word counter (STATS build only).
- frame_count  out  16  wrapping data-word counter (STATS build only).

## Operation
Shift register:
- sr[31:0] <= {sr[29:0], rx_d[0], rx_d[1]} every clock while rx_en is high.

Word classification on sr:
- DATA: sr[31:30]=2'b10, sr[16]=1, sr[15:14]=2'b01, sr[0]=0. I=sr[29:17], Q=sr[13:1].
- EOM: sr == 32'h8000_4000.
- ZERO: sr == 0.
- INVALID: anything else.

States:
- HUNT:
  - Evaluates sr every cycle; only DATA is accepted here.
  - On DATA: emit the sample, phase <= 0, miss <= 0, go to LOCKED.
  - EOM/ZERO/INVALID: ignored, no counter updates.
- LOCKED:
  - phase is a 4-bit counter that increments every cycle; a word is evaluated only when phase == 15, after which phase wraps to 0.
  - DATA: emit the sample, miss <= 0.
  - EOM: pulse eom, go to HUNT.
  - ZERO: no output, miss unchanged; this keeps lock through inter-sample idle words.
  - INVALID: miss++ and err_count++. If miss reaches MISS_LIMIT, go to HUNT with locked low.

Other rules:
- rx_en low has priority over any classification in the same cycle.
- Reset mid-word discards the partial word; after release the block is in HUNT.
- Reset values: iq_valid=0, i_out=0, q_out=0, eom=0, locked=0, err_count=0, frame_count=0, state HUNT.

## Timing
- Outputs are registered. The bit pair that completes a word is sampled at edge N and sits in sr after N; iq_valid/eom assert after edge N+1 for exactly one cycle.
- i_out/q_out hold their value until the next iq_valid.
- In LOCKED, two consecutive iq_valid strobes are at least 16 cycles apart (one word = 16 clocks).
- locked rises in the same cycle as the first iq_valid. It falls one cycle after the evaluation that ends LOCKED (MISS_LIMIT-th miss or EOM), i.e. in the same cycle as that eom strobe.
- Back-to-back DATA words give strobes exactly 16 cycles apart, with no bubble.

## Configuration
- IQ_DEFRAMER_STATS_EN defined:
  - err_count increments on each LOCKED INVALID word and saturates at 255.
  - frame_count increments on each iq_valid and wraps at 65535.
  - Both counters clear only on reset.
- Undefined: both counter outputs are tied to 0 and the counters are not built. Deframing behaviour is identical in both builds.

## Test plan
- Lock: 5 idle zero pairs, then a DATA word with I=13'h0123, Q=13'h1F00 -> iq_valid 1 cycle after the last pair, i_out=0x0123, q_out=0x1F00 (-256), locked=1.
- Idle tolerance: DATA, 3 ZERO words, DATA (I=13'h1FFF) -> strobes 64 cycles apart, locked stays 1, err_count=0.
- Loss of lock: lock, then 3 words of 32'hFFFF_FFFF -> locked=0 one cycle after the 3rd word's evaluation; err_count=3 with STATS; a subsequent DATA word at odd pair offset relocks.
- EOM: DATA, then 32'h8000_4000 -> one eom pulse, no iq_valid, locked=0.
- Misaligned hunt: a DATA word preceded by 7 random pairs that do not form a DATA pattern -> exactly one iq_valid with the correct I/Q, no false strobe.
- Async reset and rx_en: assert reset at phase 8 -> all outputs 0 immediately. Drop rx_en for 1 cycle while locked -> HUNT, and the next word is accepted only via HUNT.

Source files
------------

// File: rtl/lvds_iq_deframer.sv
// lvds_iq_deframer: locks to 32-bit LVDS I/Q words and emits 13-bit samples; IQ_DEFRAMER_STATS_EN adds err/frame counters
module lvds_iq_deframer #(
  parameter int MISS_LIMIT = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx_en,
  input  logic [1:0]  rx_d,
  output logic        iq_valid,
  output logic [12:0] i_out,
  output logic [12:0] q_out,
  output logic        eom,
  output logic        locked,
  output logic [7:0]  err_count,
  output logic [15:0] frame_count
);
  typedef enum logic {HUNT, LOCKED} state_t;
  localparam logic [3:0] LIM = 4'(MISS_LIMIT);
  state_t      r_state, w_next;
  logic [31:0] r_sr;
  logic [3:0]  r_phase, w_phase, r_miss, w_miss;
  logic        w_data, w_eomw, w_zero, w_emit, w_eom;
  assign w_data = r_sr[31:30] == 2'b10 && r_sr[16] && r_sr[15:14] == 2'b01 && !r_sr[0];
  assign w_eomw = r_sr == 32'h8000_4000;
  assign w_zero = r_sr == '0;
  // shift register, state, word phase and miss counter
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_sr    <= '0;
      r_state <= HUNT;
      r_phase <= '0;
      r_miss  <= '0;
    end else begin
      r_sr    <= rx_en ? {r_sr[29:0], rx_d[0], rx_d[1]} : '0;
      r_state <= w_next;
      r_phase <= w_phase;
      r_miss  <= w_miss;
    end
  // hunt every cycle, then evaluate one word per 16 clocks while locked
  always_comb begin
    w_next  = r_state;
    w_phase = r_phase + 4'd1;
    w_miss  = r_miss;
    w_emit  = 1'b0;
    w_eom   = 1'b0;
    if (!rx_en) begin
      w_next  = HUNT;
      w_phase = '0;
      w_miss  = '0;
    end else if (r_state == HUNT) begin
      w_phase = '0;
      if (w_data) begin
        w_emit = 1'b1;
        w_next = LOCKED;
        w_miss = '0;
      end
    end else if (r_phase == 4'd15) begin
      if (w_data) begin
        w_emit = 1'b1;
        w_miss = '0;
      end else if (w_eomw) begin
        w_eom  = 1'b1;
        w_next = HUNT;
      end else if (!w_zero) begin
        w_miss = r_miss + 4'd1;
        w_next = w_miss >= LIM ? HUNT : LOCKED;
      end
    end
  end
  // registered strobes, lock flag and held sample
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      iq_valid <= 1'b0;
      eom      <= 1'b0;
      locked   <= 1'b0;
      i_out    <= '0;
      q_out    <= '0;
    end else begin
      iq_valid <= w_emit;
      eom      <= w_eom;
      locked   <= w_next == LOCKED;
      if (w_emit) begin
        i_out <= r_sr[29:17];
        q_out <= r_sr[13:1];
      end
    end
`ifdef IQ_DEFRAMER_STATS_EN
  logic [7:0]  r_err;
  logic [15:0] r_frames;
  logic        w_err;
  assign w_err = rx_en && r_state == LOCKED && r_phase == 4'd15 && !w_data && !w_eomw && !w_zero;
  // saturating invalid-word counter and wrapping sample counter
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_err    <= '0;
      r_frames <= '0;
    end else begin
      if (w_err && r_err != 8'hFF) r_err <= r_err + 8'd1;
      if (w_emit) r_frames <= r_frames + 16'd1;
    end
  assign err_count   = r_err;
  assign frame_count = r_frames;
`else
  assign err_count   = '0;
  assign frame_count = '0;
`endif
endmodule

// File: tb/tb_lvds_iq_deframer.sv
// tb_lvds_iq_deframer: randomized scoreboard bench for lvds_iq_deframer
module tb_lvds_iq_deframer;
  localparam int ML = 3;
  logic clk = 1'b0, reset = 1'b1, rx_en = 1'b0;
  logic [1:0] rx_d = 2'b00;
  logic iq_valid, eom, locked;
  logic [12:0] i_out, q_out;
  logic [7:0] err_count;
  logic [15:0] frame_count;
  int checks = 0, failures = 0, cyc = 0;

  typedef struct {
    int cyc;
    bit v;
    bit e;
    bit lk;
    logic [12:0] i;
    logic [12:0] q;
    int err;
    int frames;
  } ev_t;
  ev_t evq[$];
  ev_t me;

  logic [31:0] m_sr;
  bit m_locked;
  int m_lock_edge, m_miss, m_err, m_frames;
  logic [12:0] m_i, m_q;

  lvds_iq_deframer #(.MISS_LIMIT(ML)) dut (
    .clk(clk), .reset(reset), .rx_en(rx_en), .rx_d(rx_d),
    .iq_valid(iq_valid), .i_out(i_out), .q_out(q_out), .eom(eom),
    .locked(locked), .err_count(err_count), .frame_count(frame_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  initial begin
    #2_000_000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  function automatic logic [31:0] mk(input logic [12:0] i, input logic [12:0] q);
    return {2'b10, i, 1'b1, 2'b01, q, 1'b0};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", nm, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    m_sr = '0; m_locked = 0; m_lock_edge = 0; m_miss = 0;
    m_err = 0; m_frames = 0; m_i = '0; m_q = '0;
  endtask

  task automatic emit(input int m, inout ev_t e);
    m_i = m_sr[29:17]; m_q = m_sr[13:1];
    e.v = 1; m_miss = 0;
    m_frames = (m_frames + 1) % 65536;
  endtask

  task automatic step(input bit en, input logic [1:0] d);
    int m = cyc + 1;
    ev_t e;
    bit dat;
    rx_en = en; rx_d = d;
    e.cyc = m; e.v = 0; e.e = 0;
    if (!en) begin
      m_sr = '0; m_locked = 0;
    end else begin
      dat = m_sr == mk(m_sr[29:17], m_sr[13:1]);
      if (!m_locked) begin
        if (dat) begin emit(m, e); m_locked = 1; m_lock_edge = m; end
      end else if ((m - m_lock_edge) % 16 == 0) begin
        if (dat) emit(m, e);
        else if (m_sr == 32'h8000_4000) begin e.e = 1; m_locked = 0; end
        else if (m_sr != 0) begin
          m_miss++;
          m_err = m_err < 255 ? m_err + 1 : 255;
          if (m_miss >= ML) m_locked = 0;
        end
      end
      m_sr = {m_sr[29:0], d[0], d[1]};
    end
    e.lk = m_locked; e.i = m_i; e.q = m_q;
`ifdef IQ_DEFRAMER_STATS_EN
    e.err = m_err; e.frames = m_frames;
`else
    e.err = 0; e.frames = 0;
`endif
    evq.push_back(e);
    @(negedge clk);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int k = 0; k < 16; k++) step(1, {w[30-2*k], w[31-2*k]});
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_iq_valid"}, iq_valid, 0);
    chk({nm, "_eom"}, eom, 0);
    chk({nm, "_locked"}, locked, 0);
    chk({nm, "_i_out"}, i_out, 0);
    chk({nm, "_q_out"}, q_out, 0);
    chk({nm, "_err_count"}, err_count, 0);
    chk({nm, "_frame_count"}, frame_count, 0);
  endtask

  always @(negedge clk)
    while (evq.size() > 0 && evq[0].cyc <= cyc) begin
      me = evq.pop_front();
      chk("iq_valid", iq_valid, me.v);
      chk("eom", eom, me.e);
      chk("locked", locked, me.lk);
      chk("i_out", i_out, me.i);
      chk("q_out", q_out, me.q);
      chk("err_count", err_count, me.err);
      chk("frame_count", frame_count, me.frames);
    end

  initial begin
    logic [12:0] ri, rq;
    logic [31:0] rw;
    int r;
    model_reset();
    repeat (3) @(negedge clk);
    chk_zero("reset");
    reset = 1'b0;
    for (int k = 0; k < 5; k++) step(1, 2'b00);
    send_word(mk(13'h0123, 13'h1F00));
    for (int k = 0; k < 48; k++) step(1, 2'b00);
    send_word(mk(13'h1FFF, 13'h0001));
    for (int k = 0; k < 3; k++) send_word(32'hFFFF_FFFF);
    step(1, 2'b11);
    send_word(mk(13'h0AAA, 13'h1555));
    send_word(mk(13'h0042, 13'h0777));
    send_word(32'h8000_4000);
    for (int k = 0; k < 7; k++) step(1, 2'($urandom));
    send_word(mk(13'h1234, 13'h0FED));
    for (int k = 0; k < 5; k++) step(1, 2'b00);
    step(0, 2'b00);
    for (int k = 0; k < 10; k++) step(1, 2'b00);
    send_word(mk(13'h0BCD, 13'h1A5A));
    for (int n = 0; n < 80; n++) begin
      r = $urandom_range(0, 11);
      ri = 13'($urandom); rq = 13'($urandom); rw = $urandom;
      if (r < 5) send_word(mk(ri, rq));
      else if (r < 7) send_word(32'h0);
      else if (r == 7) send_word(32'h8000_4000);
      else if (r == 8) send_word(rw);
      else if (r == 9) step(1, 2'(rw));
      else if (r == 10) step(0, 2'b00);
      else for (int k = 0; k < 3; k++) step(1, 2'(rw >> (2*k)));
    end
    for (int k = 0; k < 20; k++) step(1, 2'b00);
    send_word(mk(13'h0FFF, 13'h1000));
    for (int k = 0; k < 8; k++) step(1, 2'b00);
    chk("pre_reset_locked", locked, 1);
    #2 reset = 1'b1;
    #1 chk_zero("async_reset");
    evq.delete();
    model_reset();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 3; k++) step(1, 2'($urandom));
    send_word(mk(13'h0F0F, 13'h10F0));
    for (int k = 0; k < 20; k++) step(1, 2'b00);
    @(negedge clk);
    chk("scoreboard_drained", evq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
